pacman_move_check: RTL
======================

PACMAN_MOVE_CHECK -- requirements
Module: pacman_move_check

Interface
REQ-001 clk  in  1  system clock; every register updates on its rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 req  in  1  single-cycle request for a move decision, raised by the controller on each update_frame tick.
REQ-004 key_up, key_down, key_left, key_right  in  1 each  player direction keys, active-high, synchronous to clk.
REQ-005 x_in  in  8  sprite top-left x, range 0..152.
REQ-006 y_in  in  7  sprite top-left y, range 0..112.
REQ-007 rom_addr  out  15  maze ROM read address.
REQ-008 rom_q  in  1  maze ROM wall bit (1 = wall); valid one cycle after rom_addr.
REQ-009 busy  out  1  high from the cycle after req is accepted until done.
REQ-010 done  out  1  single-cycle pulse when the o_* outputs hold the new decision.
REQ-011 o_up, o_down, o_left, o_right, o_stop  out  1 each  registered one-hot move command for the position-update stage.

Function
REQ-012 Pending-direction register: loads on any cycle with exactly one key high; holds otherwise. It also loads while busy.
REQ-013 Current-direction register: holds NONE/UP/DOWN/LEFT/RIGHT.
REQ-014 In IDLE, req=1 does the following:
  - snapshots x_in, y_in, pending and current;
  - enters PROBE_P.
  - req while busy is ignored.
REQ-015 States: IDLE, PROBE_P, DRAIN_P, PROBE_C, DRAIN_C, DONE.
REQ-016 PROBE states issue 8 addresses, i=0..7, one per cycle. DRAIN states absorb the last ROM read. A phase is therefore exactly 9 cycles; there is no early abort.
REQ-017 Probe pixels per direction:
  - RIGHT (x+8, y+i)
  - LEFT (x-1, y+i)
  - UP (x+i, y-1)
  - DOWN (x+i, y+8)
REQ-018 rom_addr = y*160 + x, computed as (y<<7)+(y<<5)+x, 15-bit, no overflow for in-range probes.
REQ-019 A direction is blocked if any of its 8 rom_q samples is 1.
REQ-020 A direction is also blocked, with no probe phase, in these cases:
  - it is NONE;
  - LEFT at x=0, RIGHT at x=152;
  - UP at y=0, DOWN at y=112.
REQ-021 Pending phase:
  - if pending is clear, current takes pending and the block goes to DONE;
  - otherwise the block runs the current phase, unless current equals pending or is NONE, in which case current becomes NONE and the block goes to DONE.
REQ-022 Current phase: a clear current direction is kept; a blocked one sets current to NONE. The block then goes to DONE.
REQ-023 Latency from the req edge to the done cycle:
  - 10 cycles when the pending phase decides;
  - 19 cycles when both phases run;
  - bounds-only blocks shorten this by 9 per skipped phase; minimum 1.
REQ-024 Outputs are registered on entry to DONE: one-hot of current, with o_stop=1 when current is NONE.
REQ-025 DONE lasts 1 cycle with done=1, then IDLE. o_* hold their value until the next DONE.
REQ-026 Key changes during a check affect pending only; the check in flight uses the snapshot.

Reset
REQ-027 resetn=0 immediately forces the following, mid-operation included:
  - state to IDLE;
  - pending and current to NONE;
  - rom_addr to 0;
  - busy, done, o_up, o_down, o_left, o_right to 0;
  - o_stop to 1.
REQ-028 After resetn deasserts, the first req is honoured normally.

Structure
REQ-029 The shared package holds:
  - the direction encoding (3-bit: NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4);
  - SCREEN_W=160, SCREEN_H=120, SPRITE=8, X_MAX=152, Y_MAX=112.
REQ-030 Sub-module maze_addr (combinational x,y -> 15-bit address) is instantiated once. The FSM, probe counter, registers and wall accumulator stay in pacman_move_check.

Verification
REQ-031 Open maze, reset, key_right pulse, x=40, y=40, req -> done 10 cycles later, o_right=1, o_stop=0.
REQ-032 Wall at (48,44), current=RIGHT, pending=UP clear at x=40, y=40, req -> o_up=1, latency 10.
REQ-033 Pending DOWN blocked by wall at (43,48), current RIGHT clear, req -> o_right=1, latency 19, rom_addr sequence matches both phases.
REQ-034 Both blocked: pending LEFT walled at x=39, current UP at y=0 bounds -> o_stop=1, latency 10.
REQ-035 Second req during busy plus key_left mid-check -> ignored, decision unchanged; the next req checks LEFT.
REQ-036 resetn asserted at cycle 5 of PROBE_P -> immediately o_stop=1, busy=0; req after release -> fresh 10-cycle check.

Source files
------------

// File: rtl/pacman_move_check_pkg.sv
// Purpose : shared direction encoding, screen geometry and the edge-of-screen rule.
// Latency : n/a (types, constants and a pure function only).
// Backpres: n/a.
package pacman_move_check_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE   = 8;
    localparam int X_MAX    = 152;
    localparam int Y_MAX    = 112;

    // True when the move would leave the screen (or there is no move at all),
    // so no maze probe is needed to know it is blocked.
    function automatic logic edge_blocked(input dir_t d, input logic [7:0] x, input logic [6:0] y);
        logic b;
        case (d)
            DIR_UP:    b = (y == 7'd0);
            DIR_DOWN:  b = (y == 7'(Y_MAX));
            DIR_LEFT:  b = (x == 8'd0);
            DIR_RIGHT: b = (x == 8'(X_MAX));
            default:   b = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pacman_move_check_if.sv
// Purpose : bundle of controller/key/ROM/decision signals around the move checker.
// Latency : n/a (wires only).
// Backpres: none; req is a one-cycle pulse, ignored while busy.
// Ports   : req, key_*, x_in, y_in, rom_q towards the checker; rom_addr, busy,
//           done, o_* back from it. master = controller/ROM side, slave = checker.
interface pacman_move_check_if;
    logic        req;
    logic        key_up;
    logic        key_down;
    logic        key_left;
    logic        key_right;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [14:0] rom_addr;
    logic        rom_q;
    logic        busy;
    logic        done;
    logic        o_up;
    logic        o_down;
    logic        o_left;
    logic        o_right;
    logic        o_stop;

    modport master (
        output req, key_up, key_down, key_left, key_right, x_in, y_in, rom_q,
        input  rom_addr, busy, done, o_up, o_down, o_left, o_right, o_stop
    );

    modport slave (
        input  req, key_up, key_down, key_left, key_right, x_in, y_in, rom_q,
        output rom_addr, busy, done, o_up, o_down, o_left, o_right, o_stop
    );
endinterface

// File: rtl/maze_addr.sv
// Purpose : pixel (x,y) to maze ROM address, y*160 + x using shifts.
// Latency : combinational.
// Backpres: none.
// Ports   : x (8b), y (7b) in; addr (15b) out.
module maze_addr (
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    output logic [14:0] addr
);
    // y*160 = y*128 + y*32; fits 15 bits for any on-screen pixel.
    assign addr = {1'b0, y, 7'd0} + {3'd0, y, 5'd0} + {7'd0, x};
endmodule

// File: rtl/pacman_move_check.sv
// Purpose : decides the next sprite move by probing the maze ROM edge next to the sprite.
// Latency : 10 cycles req->done for one probe phase, 19 for two, 1 when edges decide alone.
// Backpres: req accepted only in IDLE; req while busy is dropped.
// Ports   : clk, resetn (async active-low), bus (slave modport of pacman_move_check_if).
module pacman_move_check
    import pacman_move_check_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    pacman_move_check_if.slave     bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PROBE_P = 3'd1;
    localparam logic [2:0] S_DRAIN_P = 3'd2;
    localparam logic [2:0] S_PROBE_C = 3'd3;
    localparam logic [2:0] S_DRAIN_C = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]  state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic        wall, wall_n;
    dir_t        pend, cur, cur_n, snap_pend;
    logic [7:0]  snap_x;
    logic [6:0]  snap_y;
    logic [4:0]  move_q;          // {up, down, left, right, stop}

    logic        key_vld;
    dir_t        key_dir;
    dir_t        probe_dir, chk_pend;
    logic [7:0]  px, chk_x;
    logic [6:0]  py, chk_y;
    logic [14:0] addr;
    logic        cur_skip;

    always_comb begin
        key_vld = 1'b1;
        key_dir = DIR_NONE;
        case ({bus.key_up, bus.key_down, bus.key_left, bus.key_right})
            4'b1000: key_dir = DIR_UP;
            4'b0100: key_dir = DIR_DOWN;
            4'b0010: key_dir = DIR_LEFT;
            4'b0001: key_dir = DIR_RIGHT;
            default: key_vld = 1'b0;
        endcase
    end

    // Probe pixel i of the strip just outside the sprite in the tested direction.
    always_comb begin
        probe_dir = (state == S_PROBE_C) ? cur : snap_pend;
        px = snap_x;
        py = snap_y;
        case (probe_dir)
            DIR_RIGHT: begin px = snap_x + 8'(SPRITE); py = snap_y + {4'd0, cnt}; end
            DIR_LEFT:  begin px = snap_x - 8'd1;       py = snap_y + {4'd0, cnt}; end
            DIR_UP:    begin px = snap_x + {5'd0, cnt}; py = snap_y - 7'd1;        end
            DIR_DOWN:  begin px = snap_x + {5'd0, cnt}; py = snap_y + 7'(SPRITE);  end
            default:   ;
        endcase
    end

    maze_addr u_maze_addr (.x(px), .y(py), .addr(addr));

    assign bus.rom_addr = (state == S_PROBE_P || state == S_PROBE_C) ? addr : 15'd0;

    // When pending turns out blocked, decide whether current still needs probing.
    // In IDLE this runs on live inputs, later on the snapshot taken at req.
    always_comb begin
        chk_x    = (state == S_IDLE) ? bus.x_in : snap_x;
        chk_y    = (state == S_IDLE) ? bus.y_in : snap_y;
        chk_pend = (state == S_IDLE) ? pend : snap_pend;
        cur_skip = (cur == chk_pend) || (cur == DIR_NONE) || edge_blocked(cur, chk_x, chk_y);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wall_n  = wall;
        cur_n   = cur;
        case (state)
            S_IDLE: begin
                if (bus.req) begin
                    cnt_n  = 3'd0;
                    wall_n = 1'b0;
                    if (!edge_blocked(pend, bus.x_in, bus.y_in)) begin
                        state_n = S_PROBE_P;
                    end else if (cur_skip) begin
                        cur_n   = DIR_NONE;
                        state_n = S_DONE;
                    end else begin
                        state_n = S_PROBE_C;
                    end
                end
            end
            S_PROBE_P, S_PROBE_C: begin
                // rom_q lags the address by one cycle; the first sample belongs to no probe.
                if (cnt != 3'd0) wall_n = wall | bus.rom_q;
                cnt_n = cnt + 3'd1;
                if (cnt == 3'd7) state_n = (state == S_PROBE_P) ? S_DRAIN_P : S_DRAIN_C;
            end
            S_DRAIN_P: begin
                if (!(wall | bus.rom_q)) begin
                    cur_n   = snap_pend;
                    state_n = S_DONE;
                end else if (cur_skip) begin
                    cur_n   = DIR_NONE;
                    state_n = S_DONE;
                end else begin
                    cnt_n   = 3'd0;
                    wall_n  = 1'b0;
                    state_n = S_PROBE_C;
                end
            end
            S_DRAIN_C: begin
                if (wall | bus.rom_q) cur_n = DIR_NONE;
                state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            wall      <= 1'b0;
            pend      <= DIR_NONE;
            cur       <= DIR_NONE;
            snap_pend <= DIR_NONE;
            snap_x    <= 8'd0;
            snap_y    <= 7'd0;
            move_q    <= 5'b00001;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wall  <= wall_n;
            cur   <= cur_n;
            if (key_vld) pend <= key_dir;
            if (state == S_IDLE && bus.req) begin
                snap_pend <= pend;
                snap_x    <= bus.x_in;
                snap_y    <= bus.y_in;
            end
            if (state_n == S_DONE && state != S_DONE) begin
                move_q <= {cur_n == DIR_UP, cur_n == DIR_DOWN, cur_n == DIR_LEFT,
                           cur_n == DIR_RIGHT, cur_n == DIR_NONE};
            end
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_DONE);
    assign bus.o_up    = move_q[4];
    assign bus.o_down  = move_q[3];
    assign bus.o_left  = move_q[2];
    assign bus.o_right = move_q[1];
    assign bus.o_stop  = move_q[0];

endmodule
